// File: rtl/muntjac_hpm_csr.sv
// Machine performance-monitor CSR responder: mcycle, minstret, mhpmcounter/mhpmevent, mcountinhibit and user shadows.
// Latency: request accepted in IDLE, response registered and presented the following cycle (1 request per 2 cycles).
// Backpressure: response held stable in RESP until rsp_ready_i; req_ready_o is low while a response is pending.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        request handshake; req_num_i, req_op_i, req_wdata_i, req_priv_i qualify it
//   mcounteren_i, scounteren_i     counter-enable masks for shadow reads from S/U mode
//   rsp_valid_o/rsp_ready_i        response handshake; rsp_rdata_o (pre-access value), rsp_illegal_o
//   instret_i, event_i             per-cycle retire count and event pulses feeding the counters
module muntjac_hpm_csr #(
    parameter int unsigned NumHpm    = 4,
    parameter int unsigned NumEvents = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [11:0]          req_num_i,
    input  logic [1:0]           req_op_i,
    input  logic [63:0]          req_wdata_i,
    input  logic [1:0]           req_priv_i,
    input  logic [31:0]          mcounteren_i,
    input  logic [31:0]          scounteren_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_rdata_o,
    output logic                 rsp_illegal_o,
    input  logic [1:0]           instret_i,
    input  logic [NumEvents-1:0] event_i
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [1:0] PRIV_U   = 2'd0;
    localparam logic [1:0] PRIV_S   = 2'd1;
    localparam logic [1:0] PRIV_M   = 2'd3;

    localparam int unsigned NumCnt = 3 + NumHpm;
    // Writable inhibit bits: CY, IR and one per implemented hpm counter; TM (bit 1) is hardwired 0.
    localparam logic [32:0] InhMaskWide = ((33'd1 << NumCnt) - 33'd1) & ~33'd2;
    localparam logic [31:0] InhMask     = InhMaskWide[31:0];

    typedef enum logic {IDLE, RESP} state_e;

    state_e      state;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] hpm_cnt [NumHpm];
    logic [7:0]  hpm_evt [NumHpm];
    logic [31:0] inhibit;

    logic [4:0]        idx;
    logic              is_mcnt, is_inh, is_evt, is_shadow;
    logic              priv_ok, legal, accept, wr_en;
    logic [63:0]       old_val, new_val;
    logic [7:0]        evt_new;
    logic [NumHpm-1:0] hpm_inc;

    // Address decode: low five bits select the counter index within each group.
    assign idx       = req_num_i[4:0];
    assign is_mcnt   = (req_num_i[11:5] == 7'h58) && (idx != 5'd1);
    assign is_inh    = (req_num_i == 12'h320);
    assign is_evt    = (req_num_i[11:5] == 7'h19) && (idx >= 5'd3);
    assign is_shadow = (req_num_i[11:5] == 7'h60) && (idx != 5'd1);

    always_comb begin
        priv_ok = 1'b0;
        if (is_shadow) begin
            priv_ok = (req_priv_i == PRIV_M)
                   || ((req_priv_i == PRIV_S) && mcounteren_i[idx])
                   || ((req_priv_i == PRIV_U) && mcounteren_i[idx] && scounteren_i[idx]);
        end else begin
            priv_ok = (req_priv_i == PRIV_M);
        end
    end

    // Shadows are read-only: any modifying op on them faults.
    assign legal  = (is_mcnt || is_inh || is_evt || is_shadow) && priv_ok
                 && !(is_shadow && (req_op_i != OP_READ));
    assign accept = req_valid_i && req_ready_o;
    assign wr_en  = accept && legal && (req_op_i != OP_READ);

    // Unimplemented indices fall through to zero.
    always_comb begin
        old_val = '0;
        if (is_mcnt || is_shadow) begin
            if (idx == 5'd0) old_val = mcycle;
            if (idx == 5'd2) old_val = minstret;
            for (int k = 0; k < NumHpm; k++) begin
                if (idx == 5'(k + 3)) old_val = hpm_cnt[k];
            end
        end else if (is_inh) begin
            old_val = {32'd0, inhibit};
        end else if (is_evt) begin
            for (int k = 0; k < NumHpm; k++) begin
                if (idx == 5'(k + 3)) old_val = {56'd0, hpm_evt[k]};
            end
        end
    end

    always_comb begin
        case (req_op_i)
            OP_WRITE: new_val = req_wdata_i;
            OP_SET:   new_val = old_val | req_wdata_i;
            OP_CLEAR: new_val = old_val & ~req_wdata_i;
            default:  new_val = old_val;
        endcase
    end

    // Out-of-range event selectors collapse to 0 (counter disabled).
    assign evt_new = (new_val > 64'(NumEvents)) ? 8'd0 : new_val[7:0];

    always_comb begin
        hpm_inc = '0;
        for (int k = 0; k < NumHpm; k++) begin
            for (int e = 0; e < NumEvents; e++) begin
                if ((hpm_evt[k] == 8'(e + 1)) && event_i[e]) hpm_inc[k] = 1'b1;
            end
            if (inhibit[3 + k]) hpm_inc[k] = 1'b0;
        end
    end

    // Counters: a committing write replaces the value and swallows that cycle's increment.
    // Inhibit changes only affect increments from the next edge onward.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle   <= '0;
            minstret <= '0;
            inhibit  <= '0;
            for (int k = 0; k < NumHpm; k++) begin
                hpm_cnt[k] <= '0;
                hpm_evt[k] <= '0;
            end
        end else begin
            if (wr_en && is_mcnt && (idx == 5'd0)) begin
                mcycle <= new_val;
            end else if (!inhibit[0]) begin
                mcycle <= mcycle + 64'd1;
            end
            if (wr_en && is_mcnt && (idx == 5'd2)) begin
                minstret <= new_val;
            end else if (!inhibit[2]) begin
                minstret <= minstret + {62'd0, instret_i};
            end
            for (int k = 0; k < NumHpm; k++) begin
                if (wr_en && is_mcnt && (idx == 5'(k + 3))) begin
                    hpm_cnt[k] <= new_val;
                end else if (hpm_inc[k]) begin
                    hpm_cnt[k] <= hpm_cnt[k] + 64'd1;
                end
                if (wr_en && is_evt && (idx == 5'(k + 3))) begin
                    hpm_evt[k] <= evt_new;
                end
            end
            if (wr_en && is_inh) begin
                inhibit <= new_val[31:0] & InhMask;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_illegal_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state         <= RESP;
                        req_ready_o   <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= legal ? old_val : 64'd0;
                        rsp_illegal_o <= !legal;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muntjac_hpm_csr.md
Name: muntjac_hpm_csr

Overview:
- CSR responder for the machine performance-monitoring group: mcycle, minstret, mhpmcounter3..N, mhpmevent3..N, mcountinhibit, and their user-mode read-only shadows (cycle, instret, hpmcounterN).
- Sits behind the core CSR unit. It accepts one CSR request (number, csr_op_e operation, write data, current privilege), applies it, and returns read data or an illegal flag through a valid/ready response handshake.
- Counters advance every cycle from core retire and event inputs.

Parameters:
- NumHpm, 4, number of implemented mhpmcounter/mhpmevent pairs (indices 3..3+NumHpm-1, max 29).
- NumEvents, 8, width of event_i. Legal mhpmevent values are 0..NumEvents.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_num_i  in  12  CSR number (csr_num_e)
- req_op_i  in  2  csr_op_e (READ/WRITE/SET/CLEAR)
- req_wdata_i  in  64  write/set/clear operand
- req_priv_i  in  2  priv_lvl_e of requester
- mcounteren_i  in  32  machine counter-enable
- scounteren_i  in  32  supervisor counter-enable
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  64  old CSR value (0 when illegal)
- rsp_illegal_o  out  1  access faulted
- instret_i  in  2  instructions retired this cycle (0..2)
- event_i  in  NumEvents  one-hot-or-zero event pulses this cycle

Behaviour:
- FSM has two states: IDLE and RESP.
  - IDLE: req_ready_o=1. On accept, the access is decoded and the response captured; go to RESP.
  - RESP: req_ready_o=0, rsp_valid_o=1, outputs held stable. When rsp_ready_i=1, go to IDLE. No combinational ready path; back-to-back throughput is 1 request per 2 cycles.
- Reset values:
  - state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_illegal_o=0, req_ready_o=1.
  - All counters, mhpmevent and mcountinhibit are 0.
  - Reset mid-RESP drops the response.
- Read/write semantics:
  - rdata is the pre-access value.
  - WRITE: new=wdata. SET: new=old|wdata. CLEAR: new=old&~wdata. READ never writes.
  - The write commits on the accept edge.
- Decode:
  - B00 mcycle, B02 minstret, B03+k mhpmcounter, 320 mcountinhibit, 323+k mhpmevent.
  - C00/C02/C03+k are read shadows.
  - Unimplemented indices in 3..31 read 0 and ignore writes (legal).
  - Any other number (including B01, C01 time and all xH numbers) is illegal.
- Privilege:
  - B.., 3.. addresses require req_priv_i=M.
  - Shadow index i: M always; S requires mcounteren_i[i]; U requires mcounteren_i[i] && scounteren_i[i].
  - WRITE/SET/CLEAR to any C.. address is illegal.
- Illegal access: no state change, rdata=0, illegal=1.
- WARL rules:
  - mcountinhibit bit1 and bits above 2+NumHpm hardwired 0.
  - mhpmevent write of a value >NumEvents stores 0. Only the low 8 bits are stored; upper bits read 0.
- Counting, every cycle, independent of FSM state:
  - mcycle +=1 unless inhibit[0].
  - minstret +=instret_i unless inhibit[2].
  - hpm[k] +=1 when mhpmevent[k]!=0 && event_i[mhpmevent[k]-1] && !inhibit[3+k].
  - All counters are 64-bit and wrap 2^64-1 -> 0.
- Same-cycle write and increment to one counter: the written value wins and that increment is lost. Other counters are unaffected.
- A write to mcountinhibit takes effect from the following cycle's increment.

Test Plan:
- Reset, then M-mode READ B00 after 10 idle cycles -> rsp_rdata_o=10 (±handshake offset fixed by bench), illegal=0; rsp_valid_o held until rsp_ready_i.
- WRITE B00=FFFF_FFFF_FFFF_FFFE, inhibit clear -> read two cycles later returns 0 (wrap); the write-cycle increment is lost.
- mhpmevent3 WRITE 3, pulse event_i[2] 5 times -> mhpmcounter3=5. Then WRITE mhpmevent3=200 -> read back 0; counter frozen.
- U-mode READ C02 with mcounteren_i[2]=1, scounteren_i[2]=0 -> illegal=1, rdata=0. With both set -> rdata=minstret.
- S-mode SET 320 -> illegal. M-mode SET 320 wdata=FFFF_FFFF -> read 320 returns 0x7D (NumHpm=4); mcycle stops.
- Assert rst_ni low while in RESP -> rsp_valid_o=0 immediately, req_ready_o=1, all counters 0.
